// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared states, grant classes and block geometry for the memory arbiter
package mem_arb_pkg;
    localparam int BLOCK_WORDS = 4;
    localparam int BEAT_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W = BEAT_W + 2;
    typedef enum logic [1:0] {S_IDLE, S_IRD, S_DRD, S_DWR} state_t;
    typedef enum logic [1:0] {G_NONE, G_I, G_DR, G_DW} grant_t;
endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: round-robin pick between I and D, with D writes ahead of D refills
module mem_arb_select
    import mem_arb_pkg::*;
(
    input  logic       i_elig_i,
    input  logic       dr_elig_i,
    input  logic       dw_elig_i,
    input  logic       last_d_i,
    output logic [1:0] gnt_o
);
    logic d_elig;
    assign d_elig = dr_elig_i | dw_elig_i;
    assign gnt_o  = (i_elig_i && !(d_elig && !last_d_i)) ? G_I :
                    d_elig ? (dw_elig_i ? G_DW : G_DR) : G_NONE;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port among I refill, D refill and D write-through
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic              i_abort_i,
    output logic              i_rvalid_o,
    output logic [BEAT_W-1:0] i_ridx_o,
    output logic [DATA_W-1:0] i_rdata_o,
    output logic              i_ready_o,
    input  logic              d_rreq_i,
    input  logic [ADDR_W-1:0] d_raddr_i,
    output logic              d_rvalid_o,
    output logic [BEAT_W-1:0] d_ridx_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_rready_o,
    input  logic              d_wreq_i,
    input  logic [ADDR_W-1:0] d_waddr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_wready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              busy_o
);
    state_t                state_q, state_d;
    logic                  last_d_q, last_d_d, abort_q, abort_d;
    logic [BEAT_W-1:0]     beat_q, beat_d, ridx_q, ridx_d, beat_n;
    logic [ADDR_W-1:OFF_W] base_q, base_d;
    logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d, gaddr;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
    logic                  i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic                  i_ready_q, i_ready_d, d_rready_q, d_rready_d, d_wready_q, d_wready_d;
    logic [1:0]            gnt;
    logic                  last_beat, drop;
    // a requester whose ready pulse is high is masked so it cannot be regranted on stale level
    mem_arb_select u_sel (
        .i_elig_i  (i_req_i & ~i_abort_i & ~i_ready_q),
        .dr_elig_i (d_rreq_i & ~d_rready_q),
        .dw_elig_i (d_wreq_i & ~d_wready_q),
        .last_d_i  (last_d_q),
        .gnt_o     (gnt)
    );
    assign gaddr     = (gnt == G_I) ? i_addr_i : (gnt == G_DR) ? d_raddr_i : d_waddr_i;
    assign beat_n    = beat_q + BEAT_W'(1);
    assign last_beat = (state_q == S_DWR) || (beat_q == BEAT_W'(BLOCK_WORDS - 1));
    assign drop      = (state_q == S_IRD) && (abort_q || i_abort_i);
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        abort_d     = abort_q;
        beat_d      = beat_q;
        base_d      = base_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        ridx_d      = ridx_q;
        i_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        i_ready_d   = 1'b0;
        d_rready_d  = 1'b0;
        d_wready_d  = 1'b0;
        if (state_q == S_IDLE) begin
            if (gnt != G_NONE) begin
                state_d     = (gnt == G_I) ? S_IRD : (gnt == G_DR) ? S_DRD : S_DWR;
                last_d_d    = (gnt != G_I);
                beat_d      = '0;
                base_d      = gaddr[ADDR_W-1:OFF_W];
                mem_req_d   = 1'b1;
                mem_we_d    = (gnt == G_DW);
                mem_addr_d  = (gnt == G_DW) ? gaddr : {gaddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                mem_wdata_d = d_wdata_i;
            end
        end else if (!mem_ack_i) begin
            abort_d = abort_q | ((state_q == S_IRD) & i_abort_i);
        end else begin
            // an aborted beat still has to finish on the bus, but its data is discarded
            i_rvalid_d = (state_q == S_IRD) && !drop;
            d_rvalid_d = (state_q == S_DRD);
            rdata_d    = mem_rdata_i;
            ridx_d     = beat_q;
            if (last_beat || drop) begin
                state_d    = S_IDLE;
                mem_req_d  = 1'b0;
                mem_we_d   = 1'b0;
                abort_d    = 1'b0;
                i_ready_d  = (state_q == S_IRD) && !drop;
                d_rready_d = (state_q == S_DRD);
                d_wready_d = (state_q == S_DWR);
            end else begin
                beat_d     = beat_n;
                mem_addr_d = {base_q, beat_n, 2'b00};
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_d_q    <= 1'b0;
            abort_q     <= 1'b0;
            beat_q      <= '0;
            base_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            ridx_q      <= '0;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            i_ready_q   <= 1'b0;
            d_rready_q  <= 1'b0;
            d_wready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            abort_q     <= abort_d;
            beat_q      <= beat_d;
            base_q      <= base_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ridx_q      <= ridx_d;
            i_rvalid_q  <= i_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            i_ready_q   <= i_ready_d;
            d_rready_q  <= d_rready_d;
            d_wready_q  <= d_wready_d;
        end
    end
    assign i_rvalid_o  = i_rvalid_q;
    assign i_ridx_o    = ridx_q;
    assign i_rdata_o   = rdata_q;
    assign i_ready_o   = i_ready_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign d_ridx_o    = ridx_q;
    assign d_rdata_o   = rdata_q;
    assign d_rready_o  = d_rready_q;
    assign d_wready_o  = d_wready_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = (state_q != S_IDLE);
endmodule
